// File: rtl/robot_nav_ctrl.sv
// robot_nav_ctrl: obstacle-avoidance sequencer (distance sample handshake + motion FSM).
// Define ROBOT_NAV_STATS_EN to add the saturating STOP-entry counter output obst_cnt.
module robot_nav_ctrl #(
  parameter logic [15:0] SAFE_DIST     = 16'd200,
  parameter logic [15:0] STOP_DIST     = 16'd50,
  parameter int          SAMPLE_PERIOD = 16,
  parameter int          TURN_CYCLES   = 8,
  parameter int          TIMEOUT       = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] dist_v,
  input  logic        dist_valid,
  output logic        sample_req,
  output logic        motor_en,
  output logic [1:0]  speed,
  output logic        turn,
  output logic [2:0]  state_o,
  output logic        fault
`ifdef ROBOT_NAV_STATS_EN
  ,
  output logic [7:0]  obst_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_SLOW  = 3'd2,
    S_STOP  = 3'd3,
    S_TURN  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int CW = $clog2(TURN_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt, w_cls_state;
  logic          r_req, w_req_nxt;
  logic          r_motor_en, w_motor_en_nxt;
  logic [1:0]    r_speed, w_speed_nxt, w_cls_speed;
  logic          r_turn, w_turn_nxt;
  logic          r_fault, w_fault_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic [CW-1:0] r_turn_cnt, w_turn_cnt_nxt;
  logic [WW-1:0] r_wait, w_wait_nxt;
  logic          w_hs, w_capture, w_timeout;

  assign w_capture = r_req & dist_valid;
  assign w_timeout = r_req & ~dist_valid & (r_wait == WAIT_LAST);

  // Classify the distance presented with a capture.
  always_comb begin
    if (dist_v >= SAFE_DIST) begin
      w_cls_state = S_FWD;
      w_cls_speed = 2'd2;
    end else if (dist_v >= STOP_DIST) begin
      w_cls_state = S_SLOW;
      w_cls_speed = 2'd1;
    end else begin
      w_cls_state = S_STOP;
      w_cls_speed = 2'd0;
    end
  end

  // Next-state and next-output logic; the period timer restarts at every capture.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_motor_en_nxt = r_motor_en;
    w_speed_nxt    = r_speed;
    w_turn_nxt     = r_turn;
    w_fault_nxt    = r_fault;
    w_tmr_nxt      = r_tmr;
    w_turn_cnt_nxt = r_turn_cnt;
    w_hs           = 1'b0;
    if (r_req & ~dist_valid) begin
      w_wait_nxt = r_wait + 1'b1;
    end else begin
      w_wait_nxt = '0;
    end

    case (r_state)
      S_IDLE: begin
        if (!r_req) begin
          w_req_nxt = 1'b1;
        end else begin
          w_hs = 1'b1;
        end
      end
      S_FWD, S_SLOW: begin
        if (r_req) begin
          w_hs = 1'b1;
        end else if (r_tmr == TMR_LAST) begin
          w_tmr_nxt = '0;
          w_req_nxt = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_STOP: begin
        w_state_nxt    = S_TURN;
        w_turn_nxt     = 1'b1;
        w_speed_nxt    = 2'd1;
        w_motor_en_nxt = 1'b1;
        w_turn_cnt_nxt = '0;
      end
      S_TURN: begin
        if (r_turn) begin
          if (r_turn_cnt == TURN_LAST) begin
            w_turn_nxt = 1'b0;
            w_req_nxt  = 1'b1;
          end else begin
            w_turn_cnt_nxt = r_turn_cnt + 1'b1;
          end
        end else begin
          w_hs = 1'b1;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
        w_fault_nxt = 1'b1;
      end
      default: begin
        w_state_nxt    = S_FAULT;
        w_req_nxt      = 1'b0;
        w_motor_en_nxt = 1'b0;
        w_speed_nxt    = 2'd0;
        w_turn_nxt     = 1'b0;
        w_fault_nxt    = 1'b1;
      end
    endcase

    // A valid arriving on the timeout cycle is still captured.
    if (w_hs) begin
      if (w_capture) begin
        w_state_nxt    = w_cls_state;
        w_speed_nxt    = w_cls_speed;
        w_motor_en_nxt = 1'b1;
        w_turn_nxt     = 1'b0;
        w_req_nxt      = 1'b0;
        w_tmr_nxt      = '0;
      end else if (w_timeout) begin
        w_state_nxt    = S_FAULT;
        w_req_nxt      = 1'b0;
        w_motor_en_nxt = 1'b0;
        w_speed_nxt    = 2'd0;
        w_turn_nxt     = 1'b0;
        w_fault_nxt    = 1'b1;
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      w_hs = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_motor_en <= 1'b0;
      r_speed    <= 2'd0;
      r_turn     <= 1'b0;
      r_fault    <= 1'b0;
      r_tmr      <= '0;
      r_turn_cnt <= '0;
      r_wait     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_motor_en <= w_motor_en_nxt;
      r_speed    <= w_speed_nxt;
      r_turn     <= w_turn_nxt;
      r_fault    <= w_fault_nxt;
      r_tmr      <= w_tmr_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
      r_wait     <= w_wait_nxt;
    end
  end

  assign sample_req = r_req;
  assign motor_en   = r_motor_en;
  assign speed      = r_speed;
  assign turn       = r_turn;
  assign state_o    = r_state;
  assign fault      = r_fault;

`ifdef ROBOT_NAV_STATS_EN
  logic [7:0] r_obst_cnt;

  // Saturating count of STOP entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_obst_cnt <= 8'd0;
    end else if ((w_state_nxt == S_STOP) && (r_state != S_STOP) && (r_obst_cnt != 8'd255)) begin
      r_obst_cnt <= r_obst_cnt + 8'd1;
    end else begin
      r_obst_cnt <= r_obst_cnt;
    end
  end

  assign obst_cnt = r_obst_cnt;
`endif

endmodule

// File: tb/tb_robot_nav_ctrl.sv
// Self-checking bench for robot_nav_ctrl: directed spec scenarios plus randomized
// distance samples and answer delays checked against a behavioural model.
module tb_robot_nav_ctrl;
  localparam int P  = 16;
  localparam int TC = 8;

  logic        clk, rstn, dist_valid;
  logic [15:0] dist_v;
  logic        sample_req, motor_en, turn, fault;
  logic [1:0]  speed;
  logic [2:0]  state_o;
`ifdef ROBOT_NAV_STATS_EN
  logic [7:0]  obst_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_obst = 0;

  robot_nav_ctrl dut (
    .clk(clk), .rstn(rstn), .dist_v(dist_v), .dist_valid(dist_valid),
    .sample_req(sample_req), .motor_en(motor_en), .speed(speed), .turn(turn),
    .state_o(state_o), .fault(fault)
`ifdef ROBOT_NAV_STATS_EN
    , .obst_cnt(obst_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: motion mode chosen by a captured distance.
  function automatic int exp_state_of(input int unsigned d);
    if (d >= 200) return 1;
    if (d >= 50) return 2;
    return 3;
  endfunction

  function automatic int exp_speed_of(input int unsigned d);
    if (d >= 200) return 2;
    if (d >= 50) return 1;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_req"}, sample_req, 0);
    check({tag, "_motor"}, motor_en, 0);
    check({tag, "_speed"}, speed, 0);
    check({tag, "_turn"}, turn, 0);
    check({tag, "_fault"}, fault, 0);
  endtask

  // Answer a pending request after k idle cycles, then follow the resulting behaviour
  // until the next request is raised.
  task automatic answer(input int unsigned d, input int k);
    int es, gap, tc;
    check("req_pending", sample_req, 1);
    for (int i = 0; i < k; i++) tick();
    check("req_held", sample_req, 1);
    dist_v = 16'(d);
    dist_valid = 1'b1;
    tick();
    dist_valid = 1'b0;
    es = exp_state_of(d);
    check("cap_state", state_o, es);
    check("cap_speed", speed, exp_speed_of(d));
    check("cap_motor", motor_en, 1);
    check("cap_turn", turn, 0);
    check("cap_req_drop", sample_req, 0);
    if (es == 3) begin
      exp_obst = (exp_obst < 255) ? exp_obst + 1 : 255;
      tick();
      check("turn_state", state_o, 4);
      check("turn_speed", speed, 1);
      tc = 0;
      while (turn === 1'b1 && tc < 50) begin
        tc++;
        tick();
      end
      check("turn_len", tc, TC);
      check("turn_exit_req", sample_req, 1);
      check("turn_exit_state", state_o, 4);
      check("turn_exit_speed", speed, 1);
      check("turn_exit_motor", motor_en, 1);
    end else begin
      gap = 0;
      while (sample_req !== 1'b1 && gap < 100) begin
        dist_v = 16'($urandom);
        dist_valid = 1'($urandom);
        gap++;
        tick();
      end
      dist_valid = 1'b0;
      check("period", gap, P);
      check("hold_state", state_o, es);
      check("hold_speed", speed, exp_speed_of(d));
    end
  endtask

  initial begin
    int unsigned d;
    int sel;
    int unsigned bnd[8];
    bnd = '{0, 49, 50, 51, 199, 200, 201, 65535};
    rstn = 1'b0;
    dist_valid = 1'b0;
    dist_v = 16'd0;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("idle_req", sample_req, 1);
    check("idle_state", state_o, 0);
    check("idle_motor", motor_en, 0);

    answer(300, 0);
    answer(200, 0);
    answer(50, 0);
    answer(49, 0);
    answer(500, 0);
    answer(51, 3);
    answer(199, 7);
    answer(201, 1);
    answer(0, 2);
`ifdef ROBOT_NAV_STATS_EN
    check("obst_mid", obst_cnt, exp_obst);
`endif

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: d = $urandom_range(0, 49);
        1: d = $urandom_range(50, 199);
        2: d = $urandom_range(200, 65535);
        default: d = bnd[$urandom_range(0, 7)];
      endcase
      answer(d, $urandom_range(0, 7));
    end

    dist_v = 16'd10;
    dist_valid = 1'b1;
    tick();
    dist_valid = 1'b0;
    tick();
    tick();
    tick();
    check("midturn_turn", turn, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_obst = 0;
`ifdef ROBOT_NAV_STATS_EN
    check("async_rst_obst", obst_cnt, 0);
`endif
    tick();
    rstn = 1'b1;
    tick();
    check("rerel_req", sample_req, 1);
    check("rerel_state", state_o, 0);
    check("rerel_motor", motor_en, 0);
    answer(300, 0);

`ifdef ROBOT_NAV_STATS_EN
    for (int n = 0; n < 300; n++) answer(10, 0);
    check("obst_sat", obst_cnt, exp_obst);
    check("obst_sat_255", obst_cnt, 255);
`endif

    for (int i = 0; i < 7; i++) tick();
    check("pre_timeout_req", sample_req, 1);
    check("pre_timeout_fault", fault, 0);
    tick();
    check("fault_state", state_o, 5);
    check("fault_flag", fault, 1);
    check("fault_motor", motor_en, 0);
    check("fault_req", sample_req, 0);
    check("fault_speed", speed, 0);
    check("fault_turn", turn, 0);
    for (int i = 0; i < 5; i++) begin
      dist_v = 16'd300;
      dist_valid = 1'($urandom);
      tick();
    end
    dist_valid = 1'b0;
    check("fault_sticky_state", state_o, 5);
    check("fault_sticky_flag", fault, 1);
    check("fault_sticky_motor", motor_en, 0);
    rstn = 1'b0;
    #1;
    check_all_zero("fault_rst");
    tick();
    rstn = 1'b1;
    tick();
    check("final_req", sample_req, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
